// File: rtl/programmable_delay_line_pkg.sv
// Shared constants for the filter-delay family: default geometry of the
// delay line and the encodings of its fill-state machine.
package programmable_delay_line_pkg;

  // Default geometry, shared with the other filter blocks
  localparam int cDataLength   = 16;
  localparam int cMaxDelay     = 32;
  localparam int cDefaultDelay = 16;

  // Fill-state encodings
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] PRIMED  = 2'd2;

endpackage

// File: rtl/dl_ring_ram.sv
// Single-port ring storage for the delay line. The read is read-first and
// synchronous, and it has no reset, so synthesis can map it onto block RAM.
module dl_ring_ram #(
  parameter int pDepth      = 32,
  parameter int pWidth      = 16,
  parameter int pAddrLength = 5
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [pAddrLength-1:0] i_addr,
  input  logic [pWidth-1:0]      i_wdata,
  output logic [pWidth-1:0]      o_rdata
);

  logic [pWidth-1:0] r_mem [pDepth];
  logic [pWidth-1:0] r_rdata;

  // One access per strobe: the old word is captured before the new one is stored
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_rdata        <= r_mem[i_addr];
      r_mem[i_addr]  <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/programmable_delay_line.sv
// Programmable delay line: delays pChannels bundled lanes by a run-time
// delay of 1..pMaxDelay enabled samples and flags when the output holds
// genuine delayed data, so downstream stages can align with the group delay.
module programmable_delay_line #(
  parameter int pDataLength   = programmable_delay_line_pkg::cDataLength,
  parameter int pChannels     = 1,
  parameter int pMaxDelay     = programmable_delay_line_pkg::cMaxDelay,
  parameter int pPtrLength    = $clog2(pMaxDelay),
  parameter int pCntLength    = $clog2(pMaxDelay + 1),
  parameter int pDefaultDelay = programmable_delay_line_pkg::cDefaultDelay
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             enable,
  input  logic                             delay_load,
  input  logic [pCntLength-1:0]            delay_val,
  input  logic [pChannels*pDataLength-1:0] val_in,
  output logic [pChannels*pDataLength-1:0] val_out,
  output logic                             out_valid,
  output logic [pCntLength-1:0]            delay_cur,
  output logic                             config_error
);

  import programmable_delay_line_pkg::*;

  localparam int pWordLength = pChannels * pDataLength;
  localparam logic [pCntLength-1:0] cMaxCnt     = pCntLength'(pMaxDelay);
  localparam logic [pCntLength-1:0] cDefaultCnt = pCntLength'(pDefaultDelay);

  logic [pPtrLength-1:0]  r_ptr;
  logic [pCntLength-1:0]  r_fillCnt;
  logic [pCntLength-1:0]  r_delayCur;
  logic [1:0]             r_state;
  logic [1:0]             w_stateNext;
  logic                   r_outValid;
  logic                   r_configError;
  logic                   w_loadOk;
  logic                   w_loadApply;
  logic                   w_flush;
  logic                   w_step;
  logic                   w_ptrLast;
  logic                   w_fillFull;
  logic                   w_emitNow;
  logic [pWordLength-1:0] w_ramRdata;

  // Control decode: clear outranks a load, and either flush drops a simultaneous sample
  assign w_loadOk    = (delay_val != '0) && (delay_val <= cMaxCnt);
  assign w_loadApply = delay_load && w_loadOk;
  assign w_flush     = clear || w_loadApply;
  assign w_step      = enable && !w_flush;

  // The ring only spans delay_cur words, so the pointer wraps at delay_cur-1
  assign w_ptrLast  = (pCntLength'(r_ptr) == (r_delayCur - 1'b1));
  assign w_fillFull = (r_fillCnt == r_delayCur);
  assign w_emitNow  = (r_state == PRIMED) || w_fillFull;

  // Next fill state for an enabled step; an unused encoding falls back to EMPTY
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      EMPTY:   w_stateNext = FILLING;
      FILLING: if (w_fillFull) w_stateNext = PRIMED;
      PRIMED:  w_stateNext = PRIMED;
      default: w_stateNext = EMPTY;
    endcase
  end

  // Delay currently in force; only an accepted load changes it, and clear wins over a load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_delayCur <= cDefaultCnt;
    end else if (!clear && w_loadApply) begin
      r_delayCur <= delay_val;
    end
  end

  // One-cycle flag for a load request carrying an out-of-range delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_configError <= 1'b0;
    end else begin
      r_configError <= !clear && delay_load && !w_loadOk;
    end
  end

  // Ring pointer, fill counter, fill state and output qualifier advance together on each step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_fillCnt  <= '0;
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
    end else if (w_flush) begin
      r_ptr      <= '0;
      r_fillCnt  <= '0;
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
    end else if (w_step) begin
      r_ptr      <= w_ptrLast ? '0 : r_ptr + pPtrLength'(1);
      r_fillCnt  <= w_fillFull ? r_fillCnt : r_fillCnt + pCntLength'(1);
      r_state    <= w_stateNext;
      r_outValid <= w_emitNow;
    end
  end

  dl_ring_ram #(
    .pDepth      (pMaxDelay),
    .pWidth      (pWordLength),
    .pAddrLength (pPtrLength)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_step),
    .i_addr  (r_ptr),
    .i_wdata (val_in),
    .o_rdata (w_ramRdata)
  );

  // The RAM read register only moves on a step, so gating it with the registered
  // qualifier keeps stale or unreset words off the output and zeroes it on a flush
  assign val_out      = r_outValid ? w_ramRdata : '0;
  assign out_valid    = r_outValid;
  assign delay_cur    = r_delayCur;
  assign config_error = r_configError;

endmodule

// File: tb/tb_programmable_delay_line.sv
// Directed bench for programmable_delay_line with three lanes and the
// default 32-word ring; expected values are worked out by hand per scenario.
module tb_programmable_delay_line;

  localparam int cW  = 16;
  localparam int cCh = 3;

  logic              clk;
  logic              reset_n;
  logic              clear;
  logic              enable;
  logic              delay_load;
  logic [5:0]        delay_val;
  logic [cCh*cW-1:0] val_in;
  logic [cCh*cW-1:0] val_out;
  logic              out_valid;
  logic [5:0]        delay_cur;
  logic              config_error;

  int checkCount = 0;
  int passCount  = 0;

  programmable_delay_line #(
    .pChannels (cCh)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .enable       (enable),
    .delay_load   (delay_load),
    .delay_val    (delay_val),
    .val_in       (val_in),
    .val_out      (val_out),
    .out_valid    (out_valid),
    .delay_cur    (delay_cur),
    .config_error (config_error)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [cCh*cW-1:0] lanes(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [cCh*cW-1:0] uni(input logic [15:0] v);
    return {v, v, v};
  endfunction

  // Advance one rising edge and settle just after it
  task automatic doEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic loadDelay(input logic [5:0] d);
    delay_load = 1'b1;
    delay_val  = d;
    enable     = 1'b0;
    doEdge();
    delay_load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; enable = 1'b0; delay_load = 1'b0;
    delay_val = '0; val_in = '0;
    #12;
    checkCount++;
    if (val_out !== '0) $display("[TB] FAIL reset_val got %h want 0", val_out);
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", out_valid);
    else passCount++;
    checkCount++;
    if (delay_cur !== 6'd16) $display("[TB] FAIL reset_delay got %0d want 16", delay_cur);
    else passCount++;
    checkCount++;
    if (config_error !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", config_error);
    else passCount++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_default_delay();
    logic [cCh*cW-1:0] expVal;
    for (int n = 1; n <= 20; n++) begin
      enable = 1'b1;
      val_in = uni(16'(n));
      doEdge();
      expVal = (n > 16) ? uni(16'(n - 16)) : '0;
      checkCount++;
      if (val_out !== expVal) $display("[TB] FAIL default_val step %0d got %h want %h", n, val_out, expVal);
      else passCount++;
      checkCount++;
      if (out_valid !== (n > 16)) $display("[TB] FAIL default_valid step %0d got %b want %b", n, out_valid, n > 16);
      else passCount++;
    end
  endtask

  task automatic test_delay_one();
    logic [15:0] samples [3];
    logic [cCh*cW-1:0] expVal [3];
    samples[0] = 16'hA; samples[1] = 16'hB; samples[2] = 16'hC;
    expVal[0] = '0; expVal[1] = uni(16'hA); expVal[2] = uni(16'hB);
    loadDelay(6'd1);
    checkCount++;
    if (delay_cur !== 6'd1) $display("[TB] FAIL d1_delay got %0d want 1", delay_cur);
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b0 || val_out !== '0) $display("[TB] FAIL d1_flush got %b/%h want 0/0", out_valid, val_out);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1;
      val_in = uni(samples[i]);
      doEdge();
      checkCount++;
      if (val_out !== expVal[i]) $display("[TB] FAIL d1_val step %0d got %h want %h", i + 1, val_out, expVal[i]);
      else passCount++;
    end
  endtask

  task automatic test_toggle_enable();
    int k = 0;
    logic [cCh*cW-1:0] expVal;
    loadDelay(6'd4);
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) begin
        enable = 1'b1;
        k++;
        val_in = uni(16'(16'h50 + k));
      end else begin
        enable = 1'b0;
        val_in = uni(16'hEEEE);
      end
      doEdge();
      expVal = (k >= 5) ? uni(16'(16'h50 + k - 4)) : '0;
      checkCount++;
      if (val_out !== expVal) $display("[TB] FAIL toggle_val cycle %0d got %h want %h", c, val_out, expVal);
      else passCount++;
      checkCount++;
      if (out_valid !== (k >= 5)) $display("[TB] FAIL toggle_valid cycle %0d got %b want %b", c, out_valid, k >= 5);
      else passCount++;
    end
    enable = 1'b0;
  endtask

  task automatic test_bad_load();
    logic [5:0]  badVal [4];
    logic        isLoad [4];
    badVal[0] = 6'd0; isLoad[0] = 1'b1;
    badVal[1] = 6'd0; isLoad[1] = 1'b0;
    badVal[2] = 6'd33; isLoad[2] = 1'b1;
    badVal[3] = 6'd0; isLoad[3] = 1'b0;
    loadDelay(6'd8);
    for (int n = 1; n <= 12; n++) begin
      enable = 1'b1;
      val_in = uni(16'(16'h60 + n));
      doEdge();
    end
    checkCount++;
    if (val_out !== uni(16'h64)) $display("[TB] FAIL bad_pre got %h want %h", val_out, uni(16'h64));
    else passCount++;
    for (int i = 0; i < 4; i++) begin
      enable     = 1'b1;
      delay_load = isLoad[i];
      delay_val  = badVal[i];
      val_in     = uni(16'(16'h60 + 13 + i));
      doEdge();
      checkCount++;
      if (config_error !== isLoad[i]) $display("[TB] FAIL bad_err step %0d got %b want %b", i, config_error, isLoad[i]);
      else passCount++;
      checkCount++;
      if (val_out !== uni(16'(16'h65 + i))) $display("[TB] FAIL bad_val step %0d got %h want %h", i, val_out, uni(16'(16'h65 + i)));
      else passCount++;
      checkCount++;
      if (delay_cur !== 6'd8) $display("[TB] FAIL bad_delay step %0d got %0d want 8", i, delay_cur);
      else passCount++;
    end
    delay_load = 1'b0;
  endtask

  task automatic test_clear();
    clear  = 1'b1;
    enable = 1'b1;
    val_in = uni(16'h6F);
    doEdge();
    clear = 1'b0;
    checkCount++;
    if (val_out !== '0 || out_valid !== 1'b0) $display("[TB] FAIL clear_out got %h/%b want 0/0", val_out, out_valid);
    else passCount++;
    checkCount++;
    if (delay_cur !== 6'd8) $display("[TB] FAIL clear_delay got %0d want 8", delay_cur);
    else passCount++;
    for (int m = 1; m <= 9; m++) begin
      enable = 1'b1;
      val_in = uni(16'(16'h70 + m));
      doEdge();
      checkCount++;
      if (out_valid !== (m == 9)) $display("[TB] FAIL refill_valid step %0d got %b want %b", m, out_valid, m == 9);
      else passCount++;
    end
    checkCount++;
    if (val_out !== uni(16'h71)) $display("[TB] FAIL refill_val got %h want %h", val_out, uni(16'h71));
    else passCount++;
  endtask

  task automatic test_lanes_max_and_async_reset();
    logic [cCh*cW-1:0] expVal;
    loadDelay(6'd32);
    checkCount++;
    if (delay_cur !== 6'd32) $display("[TB] FAIL max_delay got %0d want 32", delay_cur);
    else passCount++;
    for (int n = 1; n <= 40; n++) begin
      enable = 1'b1;
      val_in = lanes(16'(256 + n), 16'(512 + n), 16'(768 + n));
      doEdge();
      if (n == 32 || n == 33 || n == 40) begin
        expVal = (n > 32) ? lanes(16'(256 + n - 32), 16'(512 + n - 32), 16'(768 + n - 32)) : '0;
        checkCount++;
        if (val_out !== expVal) $display("[TB] FAIL lanes_val step %0d got %h want %h", n, val_out, expVal);
        else passCount++;
        checkCount++;
        if (out_valid !== (n > 32)) $display("[TB] FAIL lanes_valid step %0d got %b want %b", n, out_valid, n > 32);
        else passCount++;
      end
    end
    #3;
    reset_n = 1'b0;
    #1;
    checkCount++;
    if (val_out !== '0 || out_valid !== 1'b0) $display("[TB] FAIL async_out got %h/%b want 0/0", val_out, out_valid);
    else passCount++;
    checkCount++;
    if (delay_cur !== 6'd16) $display("[TB] FAIL async_delay got %0d want 16", delay_cur);
    else passCount++;
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    val_in  = uni(16'h1);
    doEdge();
    checkCount++;
    if (out_valid !== 1'b0 || val_out !== '0) $display("[TB] FAIL post_reset got %h/%b want 0/0", val_out, out_valid);
    else passCount++;
    enable = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_default_delay();
    test_delay_one();
    test_toggle_enable();
    test_bad_load();
    test_clear();
    test_lanes_max_and_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
